// File: rtl/mem_bus_responder_if.sv
// CPU memory bus between the core (master) and the memory/IO responder (slave).
// Single-request handshake: one-cycle bus_enable, answered by a one-cycle data_ready.
interface mem_bus_responder_if;
    logic [15:0] address;
    logic [31:0] data_in;
    logic [3:0]  write_mask;
    logic        bus_enable;
    logic        write_enable;
    logic [31:0] data_out;
    logic        data_ready;
    logic        bus_error;

    modport master (
        output address, data_in, write_mask, bus_enable, write_enable,
        input  data_out, data_ready, bus_error
    );

    modport slave (
        input  address, data_in, write_mask, bus_enable, write_enable,
        output data_out, data_ready, bus_error
    );
endinterface

// File: rtl/mem_bus_responder.sv
// Responder end of the CPU memory bus: on-chip RAM plus a small peripheral block
// (ioport, buttons, cycle counter, compare/match). One request in flight, fixed latency.
module mem_bus_responder #(
    parameter int          RAM_WORDS = 1024,
    parameter logic [15:0] IO_BASE   = 16'h8000
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_bus_responder_if.slave bus,
    output logic [3:0]         ioport,
    input  logic [3:0]         buttons
);
    localparam int          AW         = $clog2(RAM_WORDS);
    localparam logic [13:0] IO_WBASE   = IO_BASE[15:2];
    localparam logic [16:0] RAM_WLIMIT = 17'(RAM_WORDS);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    state_t      state_q, state_d;
    logic [13:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic        we_q, we_d;
    logic [31:0] data_out_q, data_out_d;
    logic        data_ready_q, data_ready_d;
    logic        bus_error_q, bus_error_d;
    logic [3:0]  ioport_q, ioport_d;
    logic [31:0] counter_q, counter_d;
    logic [31:0] compare_q, compare_d;
    logic        match_q, match_d;
    logic [3:0]  sync1_q, sync1_d;
    logic [3:0]  sync2_q, sync2_d;
    logic [31:0] io_rdata_q, io_rdata_d;
    logic        from_ram_q, from_ram_d;

    logic [31:0] ram [RAM_WORDS];
    logic [31:0] ram_rdata;
    logic [AW-1:0] ram_idx;
    logic        ram_we;
    logic        ram_hit, io_hit;
    logic [13:0] io_word;
    logic [31:0] io_rd;
    logic        match_clr;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^bus.address[1:0];

    assign ram_idx = addr_q[AW-1:0];
    assign ram_hit = {3'b000, addr_q} < RAM_WLIMIT;
    assign io_word = addr_q - IO_WBASE;
    assign io_hit  = (addr_q >= IO_WBASE) && (io_word <= 14'd4);
    // The FSM is forced out of ACCESS asynchronously, so a reset mid-write never commits.
    assign ram_we  = (state_q == ACCESS) && we_q && ram_hit;

    always_comb begin
        io_rd = 32'h0;
        case (io_word[2:0])
            3'd0:    io_rd = {28'h0, ioport_q};
            3'd1:    io_rd = {28'h0, ~sync2_q};
            3'd2:    io_rd = counter_q;
            3'd3:    io_rd = compare_q;
            3'd4:    io_rd = {31'h0, match_q};
            default: io_rd = 32'h0;
        endcase
    end

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old_v;
        for (int n = 0; n < 4; n++)
            if (!mask[n]) r[8*n +: 8] = new_v[8*n +: 8];
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        we_d         = we_q;
        data_out_d   = data_out_q;
        data_ready_d = 1'b0;
        bus_error_d  = bus_error_q;
        ioport_d     = ioport_q;
        counter_d    = counter_q + 32'd1;
        compare_d    = compare_q;
        match_d      = match_q;
        sync1_d      = buttons;
        sync2_d      = sync1_q;
        io_rdata_d   = io_rdata_q;
        from_ram_d   = from_ram_q;
        match_clr    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.bus_enable) begin
                    addr_d  = bus.address[15:2];
                    wdata_d = bus.data_in;
                    wmask_d = bus.write_mask;
                    we_d    = bus.write_enable;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d    = RESPOND;
                from_ram_d = ram_hit;
                io_rdata_d = io_hit ? io_rd : 32'h0;
                if (!ram_hit && !io_hit) begin
                    bus_error_d = 1'b1;
                end else if (we_q && io_hit) begin
                    case (io_word[2:0])
                        3'd0:    ioport_d  = wmask_q[0] ? ioport_q : wdata_q[3:0];
                        3'd2:    counter_d = merge(counter_q, wdata_q, wmask_q);
                        3'd3:    compare_d = merge(compare_q, wdata_q, wmask_q);
                        3'd4:    match_clr = 1'b1;
                        default: ;
                    endcase
                end
            end
            RESPOND: begin
                state_d      = IDLE;
                data_ready_d = 1'b1;
                if (!we_q) data_out_d = from_ram_q ? ram_rdata : io_rdata_q;
            end
            default: state_d = IDLE;
        endcase

        // A match in the same cycle as a clearing write keeps the flag set.
        if (match_clr) match_d = 1'b0;
        if (counter_q == compare_q) match_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            we_q         <= 1'b0;
            data_out_q   <= '0;
            data_ready_q <= 1'b0;
            bus_error_q  <= 1'b0;
            ioport_q     <= '0;
            counter_q    <= '0;
            compare_q    <= 32'hffff_ffff;
            match_q      <= 1'b0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            io_rdata_q   <= '0;
            from_ram_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            we_q         <= we_d;
            data_out_q   <= data_out_d;
            data_ready_q <= data_ready_d;
            bus_error_q  <= bus_error_d;
            ioport_q     <= ioport_d;
            counter_q    <= counter_d;
            compare_q    <= compare_d;
            match_q      <= match_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            io_rdata_q   <= io_rdata_d;
            from_ram_q   <= from_ram_d;
        end
    end

    // Byte-enable write, registered read: maps onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_we)
            for (int n = 0; n < 4; n++)
                if (!wmask_q[n]) ram[ram_idx][8*n +: 8] <= wdata_q[8*n +: 8];
        ram_rdata <= ram[ram_idx];
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_ready = data_ready_q;
    assign bus.bus_error  = bus_error_q;
    assign ioport         = ioport_q;
endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed + randomized bench for mem_bus_responder; RAM/ioport expectations come
// from a byte-lane model kept here, latency and peripheral rules checked directly.
module tb_mem_bus_responder;
    localparam logic [15:0] IO = 16'h8000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] ioport;
    logic [3:0] buttons = 4'hf;
    int         errors = 0;
    int         checks = 0;

    mem_bus_responder_if bus_if();

    mem_bus_responder #(.RAM_WORDS(1024), .IO_BASE(IO)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus_if.slave), .ioport(ioport), .buttons(buttons)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request; returns data_out when data_ready is seen. Response must
    // appear exactly two edges after the sampling edge.
    task automatic txn(input logic we, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] m, output logic [31:0] rd);
        int cyc;
        @(negedge clk);
        bus_if.address = a; bus_if.data_in = d; bus_if.write_mask = m;
        bus_if.write_enable = we; bus_if.bus_enable = 1'b1;
        @(negedge clk);
        bus_if.bus_enable = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 8; i++) begin
            if (cyc == 0) begin
                @(negedge clk);
                if (bus_if.data_ready) cyc = i;
            end
        end
        check($sformatf("latency %s %h", we ? "wr" : "rd", a), cyc, 2);
        rd = bus_if.data_out;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] dummy;
        txn(1'b1, a, d, m, dummy);
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] r);
        txn(1'b0, a, 32'h0, 4'h0, r);
    endtask

    function automatic logic [31:0] apply_mask(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] m);
        logic [31:0] r;
        r = old_v;
        for (int n = 0; n < 4; n++)
            if (m[n] == 1'b0) r[8*n +: 8] = new_v[8*n +: 8];
        return r;
    endfunction

    initial begin
        logic [31:0] r, r2, d;
        logic [3:0]  m, b, io_model;
        logic [15:0] a;
        logic [31:0] model [8];
        int          ready_seen;

        bus_if.address = '0; bus_if.data_in = '0; bus_if.write_mask = '0;
        bus_if.bus_enable = 1'b0; bus_if.write_enable = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst data_out", bus_if.data_out, 32'h0);
        check("rst data_ready", {31'h0, bus_if.data_ready}, 32'h0);
        check("rst ioport", {28'h0, ioport}, 32'h0);
        check("rst bus_error", {31'h0, bus_if.bus_error}, 32'h0);
        rd(IO + 16'h8, r);
        check("rst counter small", {31'h0, (r < 32'd64)}, 32'h1);

        // Masked RAM writes
        wr(16'h0010, 32'h12345678, 4'b0000);
        wr(16'h0010, 32'h000000AB, 4'b1110);
        rd(16'h0010, r);
        check("ram low byte", r, 32'h123456AB);
        wr(16'h0010, 32'h00AA0000, 4'b1011);
        check("data_out held on write", bus_if.data_out, 32'h123456AB);
        @(negedge clk);
        check("data_ready one cycle", {31'h0, bus_if.data_ready}, 32'h0);
        rd(16'h0010, r);
        check("ram lane2", r, 32'h12AA56AB);

        // Randomized RAM traffic on eight words
        for (int i = 0; i < 8; i++) begin
            model[i] = $urandom;
            wr(16'h0100 + 16'(i * 4), model[i], 4'b0000);
        end
        for (int i = 0; i < 40; i++) begin
            int w;
            w = $urandom_range(0, 7);
            a = 16'h0100 + 16'(w * 4) + 16'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom; m = 4'($urandom);
                wr(a, d, m);
                model[w] = apply_mask(model[w], d, m);
            end else begin
                rd(a, r);
                check($sformatf("ram rand %h", a), r, model[w]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            rd(16'h0100 + 16'(i * 4), r);
            check($sformatf("ram final %0d", i), r, model[i]);
        end

        // ioport
        io_model = 4'h0;
        for (int i = 0; i < 6; i++) begin
            d = $urandom; m = 4'($urandom);
            wr(IO, d, m);
            if (m[0] == 1'b0) io_model = d[3:0];
            check("ioport pin", {28'h0, ioport}, {28'h0, io_model});
            rd(IO, r);
            check("ioport read", r, {28'h0, io_model});
        end

        // buttons (inverted, synchronised, read-only)
        for (int i = 0; i < 3; i++) begin
            b = 4'($urandom);
            @(negedge clk);
            buttons = b;
            repeat (3) @(negedge clk);
            wr(IO + 16'h4, 32'h0000000F, 4'b0000);
            rd(IO + 16'h4, r);
            check("buttons", r, {28'h0, ~b});
        end

        // counter, compare, match flag
        wr(IO + 16'hC, 32'h5, 4'b0000);
        rd(IO + 16'hC, r);
        check("compare read", r, 32'h5);
        wr(IO + 16'h10, 32'h0, 4'b0000);
        rd(IO + 16'h10, r);
        check("match cleared", r, 32'h0);
        wr(IO + 16'h8, 32'hFFFFFFFF, 4'b0000);
        rd(IO + 16'h8, r);
        check("counter wrap window", {31'h0, (r >= 32'd1 && r <= 32'd3)}, 32'h1);
        repeat (10) @(negedge clk);
        rd(IO + 16'h10, r);
        check("match set", r, 32'h1);
        rd(IO + 16'h8, r);
        rd(IO + 16'h8, r2);
        check("counter advances", r2 - r, 32'd4);
        wr(IO + 16'h10, 32'h0, 4'b0000);
        rd(IO + 16'h10, r);
        check("match clear by write", r, 32'h0);

        // Unmapped accesses
        check("bus_error clean", {31'h0, bus_if.bus_error}, 32'h0);
        rd(16'h4000, r);
        check("unmapped read zero", r, 32'h0);
        check("bus_error set", {31'h0, bus_if.bus_error}, 32'h1);
        wr(16'h4010, 32'hDEADBEEF, 4'b0000);
        wr(IO + 16'h14, 32'hDEADBEEF, 4'b0000);
        rd(16'h0010, r);
        check("ram after unmapped", r, 32'h12AA56AB);
        check("bus_error sticky", {31'h0, bus_if.bus_error}, 32'h1);

        // Reset during ACCESS of a RAM write
        wr(16'h0200, 32'hCAFEF00D, 4'b0000);
        @(negedge clk);
        bus_if.address = 16'h0200; bus_if.data_in = 32'h11111111; bus_if.write_mask = 4'h0;
        bus_if.write_enable = 1'b1; bus_if.bus_enable = 1'b1;
        @(negedge clk);
        bus_if.bus_enable = 1'b0;
        reset_n = 1'b0;
        ready_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus_if.data_ready) ready_seen++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (bus_if.data_ready) ready_seen++;
        end
        check("no ready after abort", ready_seen, 0);
        check("bus_error reset", {31'h0, bus_if.bus_error}, 32'h0);
        check("data_out reset", bus_if.data_out, 32'h0);
        rd(16'h0200, r);
        check("aborted write dropped", r, 32'hCAFEF00D);
        rd(16'h0010, r);
        check("ram kept over reset", r, 32'h12AA56AB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
